// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one external memory port between instruction fetch (IF) and the
// data-memory stage (DM), one transaction at a time. The granted request is
// copied into the registered bus_* outputs. The completion (bus_ack or a bus
// timeout) comes back to the winner as read data plus a one-cycle ack.
// DM normally wins ties. After MAX_STREAK consecutive DM grants taken while
// IF was waiting, IF gets priority so fetch cannot starve.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   if_req/if_addr     fetch request, held until if_ack
//   if_rdata/if_ack    fetch read data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be
//                      data-stage request, held until dm_ack
//   dm_rdata/dm_ack    data read data (0 for writes) and completion pulse
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be
//                      registered copy of the granted request toward memory
//   bus_rdata/bus_ack  memory read data and completion
//   stall_fetch        if_req & ~if_ack
//   stall_mem          dm_req & ~dm_ack
//   bus_err            one-cycle pulse alongside the ack of a timed-out access
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no transfer; picks a winner (not while an ack is being shown)
// BUSY_IF | fetch access on the bus, waiting for bus_ack or timeout
// BUSY_DM | data access on the bus, waiting for bus_ack or timeout
// RESP    | result latched; the ack and bus_err go out on the next edge
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ack,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    output logic                stall_fetch,
    output logic                stall_mem,
    output logic                bus_err
);

    localparam int BE_W     = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [7:0]          TMO_LOAD   = 8'(TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state, state_next;
    logic                bus_req_next, bus_we_next;
    logic [ADDR_W-1:0]   bus_addr_next;
    logic [DATA_W-1:0]   bus_wdata_next;
    logic [BE_W-1:0]     bus_be_next;
    logic [DATA_W-1:0]   if_rdata_next, dm_rdata_next;
    logic                if_ack_next, dm_ack_next, bus_err_next;
    logic                err_flag, err_flag_next;
    logic                resp_dm, resp_dm_next;
    logic [7:0]          tmo_cnt, tmo_cnt_next;
    logic [STREAK_W-1:0] streak, streak_next;

    assign stall_fetch = if_req & ~if_ack;
    assign stall_mem   = dm_req & ~dm_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            bus_err   <= 1'b0;
            err_flag  <= 1'b0;
            resp_dm   <= 1'b0;
            tmo_cnt   <= '0;
            streak    <= '0;
        end else begin
            state     <= state_next;
            bus_req   <= bus_req_next;
            bus_we    <= bus_we_next;
            bus_addr  <= bus_addr_next;
            bus_wdata <= bus_wdata_next;
            bus_be    <= bus_be_next;
            if_rdata  <= if_rdata_next;
            dm_rdata  <= dm_rdata_next;
            if_ack    <= if_ack_next;
            dm_ack    <= dm_ack_next;
            bus_err   <= bus_err_next;
            err_flag  <= err_flag_next;
            resp_dm   <= resp_dm_next;
            tmo_cnt   <= tmo_cnt_next;
            streak    <= streak_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus_req_next   = bus_req;
        bus_we_next    = bus_we;
        bus_addr_next  = bus_addr;
        bus_wdata_next = bus_wdata;
        bus_be_next    = bus_be;
        if_rdata_next  = if_rdata;
        dm_rdata_next  = dm_rdata;
        if_ack_next    = 1'b0;
        dm_ack_next    = 1'b0;
        bus_err_next   = 1'b0;
        err_flag_next  = err_flag;
        resp_dm_next   = resp_dm;
        tmo_cnt_next   = tmo_cnt;
        streak_next    = streak;

        case (state)
            IDLE: begin
                // While an ack is showing, the acked requester's req is still
                // the old one. Skipping this cycle means the next grant sees
                // fresh requests from both sides.
                if (!(if_ack || dm_ack)) begin
                    if (if_req && (!dm_req || streak == STREAK_MAX)) begin
                        state_next     = BUSY_IF;
                        bus_req_next   = 1'b1;
                        bus_we_next    = 1'b0;
                        bus_addr_next  = if_addr;
                        bus_wdata_next = '0;
                        bus_be_next    = '1;
                        resp_dm_next   = 1'b0;
                        err_flag_next  = 1'b0;
                        tmo_cnt_next   = TMO_LOAD;
                        streak_next    = '0;
                    end else if (dm_req) begin
                        state_next     = BUSY_DM;
                        bus_req_next   = 1'b1;
                        bus_we_next    = dm_we;
                        bus_addr_next  = dm_addr;
                        bus_wdata_next = dm_wdata;
                        bus_be_next    = dm_be;
                        resp_dm_next   = 1'b1;
                        err_flag_next  = 1'b0;
                        tmo_cnt_next   = TMO_LOAD;
                        // Reaching this branch with if_req set implies
                        // streak < MAX, so the count saturates on its own.
                        if (if_req) begin
                            streak_next = streak + 1'b1;
                        end
                    end
                end
            end

            BUSY_IF, BUSY_DM: begin
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    state_next   = RESP;
                    if (state == BUSY_IF) begin
                        if_rdata_next = bus_rdata;
                    end else begin
                        dm_rdata_next = bus_we ? '0 : bus_rdata;
                    end
                end else if (tmo_cnt == '0) begin
                    bus_req_next  = 1'b0;
                    state_next    = RESP;
                    err_flag_next = 1'b1;
                    if (state == BUSY_IF) begin
                        if_rdata_next = '0;
                    end else begin
                        dm_rdata_next = '0;
                    end
                end else begin
                    tmo_cnt_next = tmo_cnt - 8'd1;
                end
            end

            RESP: begin
                if_ack_next  = ~resp_dm;
                dm_ack_next  = resp_dm;
                bus_err_next = err_flag;
                state_next   = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed scenarios followed by randomized rounds. Each round is planned at
// transaction level: an ordered list of grants comes from the priority and
// streak rules. A bus responder answers each grant after a chosen latency or
// never answers it. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;
    localparam int TIMEOUT    = 15;
    localparam int MAX_STREAK = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [BE_W-1:0]   dm_be;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [BE_W-1:0]   bus_be;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              stall_fetch;
    logic              stall_mem;
    logic              bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .stall_fetch(stall_fetch), .stall_mem(stall_mem),
        .bus_err(bus_err)
    );

    int n_asserts = 0;
    int n_fail    = 0;
    int streak_m  = 0;

    // Round description: requester fields and per-grant bus behaviour.
    // A latency of -1 means the bus never answers that grant.
    logic [31:0] if_addr_v;
    logic        dm_we_q[8];
    logic [31:0] dm_addr_q[8];
    logic [31:0] dm_wdata_q[8];
    logic [3:0]  dm_be_q[8];
    int          lat_q[16];
    logic [31:0] rd_q[16];
    int          order_q[16];
    int          dmi_q[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant order under the rules: DM first, except that IF wins once it has
    // watched MAX_STREAK DM grants go by. An IF grant clears the count.
    task automatic plan_order(input bit do_if, input int n_dm, output int n_gr);
        bit if_pend;
        int dm_rem;
        int d;
        if_pend = do_if;
        dm_rem  = n_dm;
        n_gr    = 0;
        d       = 0;
        while (if_pend || dm_rem > 0) begin
            if (if_pend && (dm_rem == 0 || streak_m == MAX_STREAK)) begin
                order_q[n_gr] = 0;
                if_pend  = 1'b0;
                streak_m = 0;
            end else begin
                order_q[n_gr] = 1;
                dmi_q[n_gr]   = d;
                d++;
                dm_rem--;
                if (if_pend && streak_m < MAX_STREAK) streak_m++;
            end
            n_gr++;
        end
    endtask

    task automatic present_dm(input int i);
        dm_req   = 1'b1;
        dm_we    = dm_we_q[i];
        dm_addr  = dm_addr_q[i];
        dm_wdata = dm_wdata_q[i];
        dm_be    = dm_be_q[i];
    endtask

    task automatic fill_random();
        if_addr_v = $urandom;
        for (int i = 0; i < 8; i++) begin
            dm_we_q[i]    = 1'($urandom_range(0, 1));
            dm_addr_q[i]  = $urandom;
            dm_wdata_q[i] = $urandom;
            dm_be_q[i]    = 4'($urandom_range(0, 15));
        end
        for (int i = 0; i < 16; i++) begin
            lat_q[i] = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 3));
            rd_q[i]  = $urandom;
        end
    endtask

    task automatic run_round(input bit do_if, input int n_dm);
        int n_gr, granted, acked, cyc, hi_cnt, dm_cur, k;
        int grant_cyc[16];
        bit if_drop, dm_adv, prev_breq, exp_err;
        logic [31:0] exp_rd;

        plan_order(do_if, n_dm, n_gr);
        @(negedge clk);
        if (do_if) begin
            if_req  = 1'b1;
            if_addr = if_addr_v;
        end
        dm_cur = 0;
        if (n_dm > 0) present_dm(0);
        granted   = 0;
        acked     = 0;
        cyc       = 0;
        hi_cnt    = 0;
        if_drop   = 1'b0;
        dm_adv    = 1'b0;
        prev_breq = bus_req;

        while ((acked < n_gr || if_req || dm_req) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            chk("stall_fetch", 64'(stall_fetch), 64'(if_req & ~if_ack));
            chk("stall_mem", 64'(stall_mem), 64'(dm_req & ~dm_ack));
            chk("ack_exclusive", 64'(if_ack & dm_ack), 64'(0));

            if (bus_req && !prev_breq) begin
                if (granted < n_gr) begin
                    k = granted;
                    if (order_q[k] == 1) begin
                        chk("grant_dm_we", 64'(bus_we), 64'(dm_we_q[dmi_q[k]]));
                        chk("grant_dm_addr", 64'(bus_addr), 64'(dm_addr_q[dmi_q[k]]));
                        chk("grant_dm_wdata", 64'(bus_wdata), 64'(dm_wdata_q[dmi_q[k]]));
                        chk("grant_dm_be", 64'(bus_be), 64'(dm_be_q[dmi_q[k]]));
                    end else begin
                        chk("grant_if_we", 64'(bus_we), 64'(0));
                        chk("grant_if_addr", 64'(bus_addr), 64'(if_addr_v));
                    end
                    grant_cyc[k] = cyc;
                end else begin
                    chk("extra_grant", 64'(bus_req), 64'(0));
                end
                granted++;
                hi_cnt = 0;
            end

            if (!bus_req && prev_breq && granted > 0 && granted <= n_gr) begin
                k = granted - 1;
                chk("bus_req_len", 64'(hi_cnt), 64'((lat_q[k] < 0) ? TIMEOUT : lat_q[k] + 1));
            end

            exp_err = 1'b0;
            if (if_ack || dm_ack) begin
                if (acked < granted && acked < n_gr) begin
                    k = acked;
                    chk("ack_who", 64'({if_ack, dm_ack}), 64'((order_q[k] == 1) ? 2'b01 : 2'b10));
                    chk("ack_latency", 64'(cyc - grant_cyc[k]),
                        64'((lat_q[k] < 0) ? TIMEOUT + 1 : lat_q[k] + 2));
                    if (lat_q[k] < 0) exp_rd = '0;
                    else if (order_q[k] == 1 && dm_we_q[dmi_q[k]]) exp_rd = '0;
                    else exp_rd = rd_q[k];
                    if (order_q[k] == 1) chk("dm_rdata", 64'(dm_rdata), 64'(exp_rd));
                    else chk("if_rdata", 64'(if_rdata), 64'(exp_rd));
                    exp_err = (lat_q[k] < 0);
                end else begin
                    chk("spurious_ack", 64'({if_ack, dm_ack}), 64'(0));
                end
                acked++;
            end
            chk("bus_err", 64'(bus_err), 64'(exp_err));

            // Requesters let go (or present the next access) one cycle after their ack.
            if (if_drop) begin
                if_req  = 1'b0;
                if_drop = 1'b0;
            end
            if (dm_adv) begin
                dm_cur++;
                if (dm_cur < n_dm) present_dm(dm_cur);
                else dm_req = 1'b0;
                dm_adv = 1'b0;
            end
            if (if_ack) if_drop = 1'b1;
            if (dm_ack) dm_adv = 1'b1;

            if (bus_req) begin
                hi_cnt++;
                k = (granted > 0) ? granted - 1 : 0;
                bus_ack   = (lat_q[k] >= 0 && hi_cnt == lat_q[k] + 1);
                bus_rdata = bus_ack ? rd_q[k] : $urandom;
            end else begin
                bus_ack   = ($urandom_range(0, 3) == 0);
                bus_rdata = $urandom;
            end
            prev_breq = bus_req;
        end
        chk("round_grants", 64'(granted), 64'(n_gr));
        chk("round_acks", 64'(acked), 64'(n_gr));
        bus_ack = 1'b0;
        if_req  = 1'b0;
        dm_req  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_req"}, 64'(bus_req), 64'(0));
        chk({tag, "_bus_we"}, 64'(bus_we), 64'(0));
        chk({tag, "_bus_addr"}, 64'(bus_addr), 64'(0));
        chk({tag, "_bus_wdata"}, 64'(bus_wdata), 64'(0));
        chk({tag, "_bus_be"}, 64'(bus_be), 64'(0));
        chk({tag, "_if_ack"}, 64'(if_ack), 64'(0));
        chk({tag, "_dm_ack"}, 64'(dm_ack), 64'(0));
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'(0));
        chk({tag, "_dm_rdata"}, 64'(dm_rdata), 64'(0));
        chk({tag, "_bus_err"}, 64'(bus_err), 64'(0));
        chk({tag, "_stall_fetch"}, 64'(stall_fetch), 64'(0));
        chk({tag, "_stall_mem"}, 64'(stall_mem), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit do_if;
        int n_dm;

        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_be     = '0;
        bus_rdata = '0;
        bus_ack   = 1'b0;

        // Reset for three cycles with no requests: everything low.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("post_reset");

        // Reset in the middle of a bus access: bus_req drops, no ack follows.
        if_req  = 1'b1;
        if_addr = 32'h300;
        @(negedge clk);
        chk("midrst_busreq_up", 64'(bus_req), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busreq_down", 64'(bus_req), 64'(0));
        chk("midrst_if_ack", 64'(if_ack), 64'(0));
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_ack", 64'({if_ack, dm_ack, bus_err}), 64'(0));
            chk("midrst_idle", 64'(bus_req), 64'(0));
        end
        streak_m = 0;

        // IF read, memory answers immediately.
        fill_random();
        if_addr_v = 32'h100;
        lat_q[0]  = 0;
        rd_q[0]   = 32'hDEADBEEF;
        run_round(1'b1, 0);
        chk("if_read_data", 64'(if_rdata), 64'(32'hDEADBEEF));

        // Simultaneous requests: DM write first, then IF.
        fill_random();
        dm_we_q[0]    = 1'b1;
        dm_addr_q[0]  = 32'h200;
        dm_wdata_q[0] = 32'h12345678;
        dm_be_q[0]    = 4'hF;
        if_addr_v     = 32'h104;
        lat_q[0]      = 0;
        lat_q[1]      = 1;
        rd_q[0]       = 32'hAAAA5555;
        rd_q[1]       = 32'hCAFEF00D;
        run_round(1'b1, 1);
        chk("dm_write_rdata", 64'(dm_rdata), 64'(0));

        // DM streaming with IF held: IF gets in after four DM grants. Run it
        // twice so a streak that fails to clear shows up in the second pass.
        fill_random();
        for (int i = 0; i < 16; i++) lat_q[i] = 0;
        run_round(1'b1, 6);
        fill_random();
        for (int i = 0; i < 16; i++) lat_q[i] = i % 3;
        run_round(1'b1, 5);

        // DM read with no answer from the bus: abort, error pulse, zero data.
        fill_random();
        dm_we_q[0]   = 1'b0;
        dm_addr_q[0] = 32'h400;
        lat_q[0]     = -1;
        run_round(1'b0, 1);

        // Stray bus_ack while idle changes nothing.
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h5A5A5A5A;
        repeat (4) begin
            @(negedge clk);
            chk("stray_bus_req", 64'(bus_req), 64'(0));
            chk("stray_acks", 64'({if_ack, dm_ack, bus_err}), 64'(0));
            chk("stray_stalls", 64'({stall_fetch, stall_mem}), 64'(0));
        end
        bus_ack = 1'b0;
        fill_random();
        lat_q[0] = 2;
        run_round(1'b1, 0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            fill_random();
            case ($urandom_range(0, 3))
                0: begin do_if = 1'b1; n_dm = 0; end
                1: begin do_if = 1'b0; n_dm = int'($urandom_range(1, 3)); end
                2: begin do_if = 1'b1; n_dm = 1; end
                default: begin do_if = 1'b1; n_dm = int'($urandom_range(2, 6)); end
            endcase
            run_round(do_if, n_dm);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
